// File: rtl/piece_move_sequencer.sv
`default_nettype none
// ============================================================================
// piece_move_sequencer : falling-piece control FSM with one shared collision check
// Revision 1.0
// ============================================================================
module piece_move_sequencer #(
    parameter int X_ORI    = 6,
    parameter int Y_ORI    = 20,
    parameter int DROP_MAX = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [2:0] key_code,
    input  logic       tick,
    output logic       chk_req,
    output logic [3:0] chk_x,
    output logic [4:0] chk_y,
    output logic [1:0] chk_shape,
    input  logic       chk_ok,
    output logic [3:0] pos_x,
    output logic [4:0] pos_y,
    output logic       rot_cw,
    output logic       rot_ccw,
    output logic       lock_req,
    input  logic       lock_done,
    output logic       spawn,
    output logic       clear_req,
    output logic       game_over,
    output logic       busy
);

    localparam int         CNT_W = $clog2(DROP_MAX + 1);
    localparam logic [3:0] C_X0  = X_ORI[3:0];
    localparam logic [4:0] C_Y0  = Y_ORI[4:0];

    localparam logic [2:0] C_OP_TICK  = 3'd0;
    localparam logic [2:0] C_OP_DROP  = 3'd2;
    localparam logic [2:0] C_OP_CW    = 3'd3;
    localparam logic [2:0] C_OP_CCW   = 3'd4;
    localparam logic [2:0] C_OP_LEFT  = 3'd5;
    localparam logic [2:0] C_OP_RIGHT = 3'd6;

    typedef enum logic [2:0] {
        S_OVER       = 3'd0,
        S_READY      = 3'd1,
        S_ISSUE      = 3'd2,
        S_EVAL       = 3'd3,
        S_LOCK       = 3'd4,
        S_LOCK_WAIT  = 3'd5,
        S_SPAWN      = 3'd6,
        S_SPAWN_EVAL = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         pos_x_q, pos_x_d;
    logic [4:0]         pos_y_q, pos_y_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               kbuf_vld_q, kbuf_vld_d;
    logic [2:0]         kbuf_code_q, kbuf_code_d;
    logic               tick_pend_q, tick_pend_d;
    logic               rot_cw_q, rot_cw_d;
    logic               rot_ccw_q, rot_ccw_d;
    logic               clear_req_q, clear_req_d;

    logic               w_key_move;
    logic               w_key_start;
    logic [3:0]         w_cand_x;
    logic [4:0]         w_cand_y;
    logic [1:0]         w_cand_shape;

    assign w_key_move  = key_valid && (key_code >= 3'd2) && (key_code <= 3'd6);
    assign w_key_start = key_valid && (key_code == 3'd1);

    // Candidate derives from the committed position, so a hard-drop step
    // re-issued from EVAL automatically targets the next row down.
    always_comb begin
        w_cand_x     = pos_x_q;
        w_cand_y     = pos_y_q;
        w_cand_shape = 2'd0;
        case (op_q)
            C_OP_CW:    w_cand_shape = 2'd1;
            C_OP_CCW:   w_cand_shape = 2'd2;
            C_OP_LEFT:  w_cand_x     = pos_x_q - 4'd1;
            C_OP_RIGHT: w_cand_x     = pos_x_q + 4'd1;
            default:    w_cand_y     = pos_y_q - 5'd1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        op_d        = op_q;
        drop_cnt_d  = drop_cnt_q;
        kbuf_vld_d  = kbuf_vld_q;
        kbuf_code_d = kbuf_code_q;
        tick_pend_d = tick_pend_q;
        rot_cw_d    = 1'b0;
        rot_ccw_d   = 1'b0;
        clear_req_d = 1'b0;

        if (state_q != S_OVER) begin
            tick_pend_d = tick_pend_q | tick;
            if (w_key_move && !kbuf_vld_q) begin
                kbuf_vld_d  = 1'b1;
                kbuf_code_d = key_code;
            end
        end

        case (state_q)
            S_READY: begin
                // An incoming key with an empty buffer is served directly so
                // the check request follows the key by a single cycle.
                if (kbuf_vld_q) begin
                    op_d       = kbuf_code_q;
                    kbuf_vld_d = 1'b0;
                    drop_cnt_d = '0;
                    state_d    = S_ISSUE;
                end else if (w_key_move) begin
                    op_d       = key_code;
                    kbuf_vld_d = 1'b0;
                    drop_cnt_d = '0;
                    state_d    = S_ISSUE;
                end else if (tick_pend_q) begin
                    op_d        = C_OP_TICK;
                    tick_pend_d = tick;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_EVAL;
            S_EVAL: begin
                state_d = S_READY;
                if (chk_ok) begin
                    case (op_q)
                        C_OP_CW:    rot_cw_d  = 1'b1;
                        C_OP_CCW:   rot_ccw_d = 1'b1;
                        C_OP_LEFT,
                        C_OP_RIGHT: pos_x_d   = w_cand_x;
                        C_OP_DROP: begin
                            pos_y_d    = w_cand_y;
                            drop_cnt_d = drop_cnt_q + CNT_W'(1);
                            state_d    = (drop_cnt_q < CNT_W'(DROP_MAX - 1)) ? S_ISSUE : S_LOCK;
                        end
                        default:    pos_y_d   = w_cand_y;
                    endcase
                end else if (op_q == C_OP_TICK || op_q == C_OP_DROP) begin
                    state_d = S_LOCK;
                end
            end
            S_LOCK: state_d = S_LOCK_WAIT;
            S_LOCK_WAIT: begin
                if (lock_done) begin
                    pos_x_d = C_X0;
                    pos_y_d = C_Y0;
                    state_d = S_SPAWN;
                end
            end
            S_SPAWN:      state_d = S_SPAWN_EVAL;
            S_SPAWN_EVAL: state_d = chk_ok ? S_READY : S_OVER;
            default:      state_d = S_OVER;
        endcase

        if (w_key_start) begin
            state_d     = S_SPAWN;
            pos_x_d     = C_X0;
            pos_y_d     = C_Y0;
            kbuf_vld_d  = 1'b0;
            tick_pend_d = 1'b0;
            drop_cnt_d  = '0;
            rot_cw_d    = 1'b0;
            rot_ccw_d   = 1'b0;
            clear_req_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OVER;
            pos_x_q     <= C_X0;
            pos_y_q     <= C_Y0;
            op_q        <= C_OP_TICK;
            drop_cnt_q  <= '0;
            kbuf_vld_q  <= 1'b0;
            kbuf_code_q <= 3'd0;
            tick_pend_q <= 1'b0;
            rot_cw_q    <= 1'b0;
            rot_ccw_q   <= 1'b0;
            clear_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            op_q        <= op_d;
            drop_cnt_q  <= drop_cnt_d;
            kbuf_vld_q  <= kbuf_vld_d;
            kbuf_code_q <= kbuf_code_d;
            tick_pend_q <= tick_pend_d;
            rot_cw_q    <= rot_cw_d;
            rot_ccw_q   <= rot_ccw_d;
            clear_req_q <= clear_req_d;
        end
    end

    assign chk_req   = (state_q == S_ISSUE) || (state_q == S_SPAWN);
    assign chk_x     = (state_q == S_SPAWN) ? pos_x_q : w_cand_x;
    assign chk_y     = (state_q == S_SPAWN) ? pos_y_q : w_cand_y;
    assign chk_shape = (state_q == S_SPAWN) ? 2'd0    : w_cand_shape;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign rot_cw    = rot_cw_q;
    assign rot_ccw   = rot_ccw_q;
    assign lock_req  = (state_q == S_LOCK);
    assign spawn     = (state_q == S_SPAWN);
    assign clear_req = clear_req_q;
    assign game_over = (state_q == S_OVER);
    assign busy      = (state_q != S_READY) && (state_q != S_OVER);

endmodule
`default_nettype wire

// File: tb/tb_piece_move_sequencer.sv
`default_nettype none
// ============================================================================
// tb_piece_move_sequencer : scoreboard bench; expected checker transactions are
// queued with stimulus and the checker response is returned from the queue.
// Revision 1.0
// ============================================================================
module tb_piece_move_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [2:0] key_code = 3'd0;
    logic       tick = 1'b0;
    logic       chk_ok = 1'b0;
    logic       lock_done = 1'b0;
    logic       chk_req;
    logic [3:0] chk_x;
    logic [4:0] chk_y;
    logic [1:0] chk_shape;
    logic [3:0] pos_x;
    logic [4:0] pos_y;
    logic       rot_cw, rot_ccw, lock_req, spawn, clear_req, game_over, busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] x;
        logic [4:0] y;
        logic [1:0] shape;
        logic       ok;
    } chk_t;

    chk_t exp_q[$];

    piece_move_sequencer #(.X_ORI(6), .Y_ORI(20), .DROP_MAX(24)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .tick(tick), .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y),
        .chk_shape(chk_shape), .chk_ok(chk_ok), .pos_x(pos_x), .pos_y(pos_y),
        .rot_cw(rot_cw), .rot_ccw(rot_ccw), .lock_req(lock_req),
        .lock_done(lock_done), .spawn(spawn), .clear_req(clear_req),
        .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    // Checker model: pops the expected request and answers it for the EVAL cycle.
    always @(negedge clk) begin
        if (rst_n && chk_req) begin
            chk_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL chk_unexpected got x=%0d y=%0d shape=%0d, none expected",
                         chk_x, chk_y, chk_shape);
                chk_ok = 1'b0;
            end else begin
                e = exp_q.pop_front();
                if ({chk_x, chk_y, chk_shape} !== {e.x, e.y, e.shape}) begin
                    failures++;
                    $display("FAIL chk_txn got x=%0d y=%0d shape=%0d exp x=%0d y=%0d shape=%0d",
                             chk_x, chk_y, chk_shape, e.x, e.y, e.shape);
                end
                chk_ok = e.ok;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_key(input logic [2:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 3'd0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic pulse_lock_done();
        lock_done = 1'b1;
        @(posedge clk);
        #1;
        lock_done = 1'b0;
    endtask

    task automatic push(input int x, input int y, input int shape, input logic ok);
        chk_t e;
        e.x = x[3:0]; e.y = y[4:0]; e.shape = shape[1:0]; e.ok = ok;
        exp_q.push_back(e);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s pending_checks=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        step(3);
        checks++;
        if ({game_over, busy, pos_x, pos_y} !== {1'b1, 1'b0, 4'd6, 5'd20}) begin
            failures++;
            $display("FAIL reset_state go=%0b busy=%0b pos=(%0d,%0d) exp go=1 busy=0 pos=(6,20)",
                     game_over, busy, pos_x, pos_y);
        end
        checks++;
        if ({chk_req, rot_cw, rot_ccw, lock_req, spawn, clear_req} !== 6'b0) begin
            failures++;
            $display("FAIL reset_pulses got %b exp 000000",
                     {chk_req, rot_cw, rot_ccw, lock_req, spawn, clear_req});
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_start();
        push(6, 20, 0, 1'b1);
        pulse_key(3'd1);
        checks++;
        if ({clear_req, spawn, game_over, pos_x, pos_y} !== {1'b1, 1'b1, 1'b0, 4'd6, 5'd20}) begin
            failures++;
            $display("FAIL start_pulse clr=%0b spawn=%0b go=%0b pos=(%0d,%0d) exp 1 1 0 (6,20)",
                     clear_req, spawn, game_over, pos_x, pos_y);
        end
        step(2);
        checks++;
        if ({busy, game_over, clear_req, spawn} !== 4'b0) begin
            failures++;
            $display("FAIL start_ready busy=%0b go=%0b clr=%0b spawn=%0b exp all 0",
                     busy, game_over, clear_req, spawn);
        end
        check_drained("start_drain");
    endtask

    task automatic test_moves();
        push(5, 20, 0, 1'b1);
        pulse_key(3'd5);
        step(1);
        checks++;
        if (pos_x !== 4'd6) begin
            failures++;
            $display("FAIL left_latency pos_x=%0d exp 6", pos_x);
        end
        step(1);
        checks++;
        if ({pos_x, busy} !== {4'd5, 1'b0}) begin
            failures++;
            $display("FAIL left_ok pos_x=%0d busy=%0b exp 5 0", pos_x, busy);
        end
        push(4, 20, 0, 1'b0);
        pulse_key(3'd5);
        step(2);
        checks++;
        if ({pos_x, pos_y, rot_cw, rot_ccw, lock_req, busy} !== {4'd5, 5'd20, 4'b0}) begin
            failures++;
            $display("FAIL left_blocked pos=(%0d,%0d) cw=%0b ccw=%0b lock=%0b busy=%0b exp (5,20) 0 0 0 0",
                     pos_x, pos_y, rot_cw, rot_ccw, lock_req, busy);
        end
        push(6, 20, 0, 1'b1);
        pulse_key(3'd6);
        step(2);
        checks++;
        if (pos_x !== 4'd6) begin
            failures++;
            $display("FAIL right_ok pos_x=%0d exp 6", pos_x);
        end
        push(6, 20, 2, 1'b1);
        pulse_key(3'd4);
        step(2);
        checks++;
        if ({rot_ccw, rot_cw, pos_x, pos_y} !== {1'b1, 1'b0, 4'd6, 5'd20}) begin
            failures++;
            $display("FAIL ccw_ok ccw=%0b cw=%0b pos=(%0d,%0d) exp 1 0 (6,20)",
                     rot_ccw, rot_cw, pos_x, pos_y);
        end
        step(2);
        check_drained("moves_drain");
    endtask

    task automatic test_key_and_tick();
        push(6, 20, 1, 1'b1);
        push(6, 19, 0, 1'b1);
        key_valid = 1'b1;
        key_code  = 3'd3;
        tick      = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 3'd0;
        tick      = 1'b0;
        step(2);
        checks++;
        if ({rot_cw, pos_y} !== {1'b1, 5'd20}) begin
            failures++;
            $display("FAIL key_tick_rot cw=%0b pos_y=%0d exp 1 20", rot_cw, pos_y);
        end
        step(3);
        checks++;
        if ({rot_cw, pos_y} !== {1'b0, 5'd19}) begin
            failures++;
            $display("FAIL key_tick_down cw=%0b pos_y=%0d exp 0 19", rot_cw, pos_y);
        end
        step(2);
        check_drained("key_tick_drain");
    endtask

    task automatic test_back_to_back();
        push(5, 19, 0, 1'b1);
        push(6, 19, 0, 1'b1);
        pulse_key(3'd5);
        pulse_key(3'd6);
        pulse_key(3'd4);
        checks++;
        if (pos_x !== 4'd5) begin
            failures++;
            $display("FAIL b2b_first pos_x=%0d exp 5", pos_x);
        end
        step(3);
        checks++;
        if ({pos_x, rot_ccw} !== {4'd6, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second pos_x=%0d ccw=%0b exp 6 0", pos_x, rot_ccw);
        end
        step(4);
        check_drained("b2b_drain");
    endtask

    task automatic test_hard_drop();
        push(6, 20, 0, 1'b1);
        pulse_key(3'd1);
        step(2);
        pulse_lock_done();
        checks++;
        if ({spawn, busy} !== 2'b00) begin
            failures++;
            $display("FAIL stray_lock_done spawn=%0b busy=%0b exp 0 0", spawn, busy);
        end
        for (int y = 19; y >= 15; y--) push(6, y, 0, 1'b1);
        push(6, 14, 0, 1'b0);
        pulse_key(3'd2);
        step(11);
        checks++;
        if (lock_req !== 1'b0) begin
            failures++;
            $display("FAIL drop_early_lock lock_req=%0b exp 0", lock_req);
        end
        step(1);
        checks++;
        if ({lock_req, pos_y, busy} !== {1'b1, 5'd15, 1'b1}) begin
            failures++;
            $display("FAIL drop_lock lock_req=%0b pos_y=%0d busy=%0b exp 1 15 1",
                     lock_req, pos_y, busy);
        end
        step(1);
        pulse_tick();
        pulse_tick();
        step(1);
        pulse_tick();
        checks++;
        if ({lock_req, busy, chk_req} !== {1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL lock_wait lock_req=%0b busy=%0b chk_req=%0b exp 0 1 0",
                     lock_req, busy, chk_req);
        end
        push(6, 20, 0, 1'b1);
        push(6, 19, 0, 1'b1);
        pulse_lock_done();
        checks++;
        if ({spawn, clear_req, pos_x, pos_y} !== {1'b1, 1'b0, 4'd6, 5'd20}) begin
            failures++;
            $display("FAIL relock_spawn spawn=%0b clr=%0b pos=(%0d,%0d) exp 1 0 (6,20)",
                     spawn, clear_req, pos_x, pos_y);
        end
        step(5);
        checks++;
        if (pos_y !== 5'd19) begin
            failures++;
            $display("FAIL pending_tick pos_y=%0d exp 19", pos_y);
        end
        step(6);
        check_drained("drop_drain");
    endtask

    task automatic test_drop_max();
        for (int k = 1; k <= 24; k++) push(6, (19 - k + 32) % 32, 0, 1'b1);
        pulse_key(3'd2);
        step(47);
        checks++;
        if (lock_req !== 1'b0) begin
            failures++;
            $display("FAIL dropmax_early lock_req=%0b exp 0", lock_req);
        end
        step(1);
        checks++;
        if ({lock_req, pos_y} !== {1'b1, 5'd27}) begin
            failures++;
            $display("FAIL dropmax_lock lock_req=%0b pos_y=%0d exp 1 27", lock_req, pos_y);
        end
        check_drained("dropmax_drain");
        step(1);
        push(6, 20, 0, 1'b1);
        pulse_lock_done();
        step(3);
        check_drained("dropmax_spawn_drain");
    endtask

    task automatic test_game_over();
        push(6, 20, 0, 1'b0);
        pulse_key(3'd1);
        step(2);
        checks++;
        if ({game_over, busy} !== 2'b10) begin
            failures++;
            $display("FAIL spawn_blocked go=%0b busy=%0b exp 1 0", game_over, busy);
        end
        for (int c = 2; c <= 6; c++) begin
            pulse_key(3'(c));
            pulse_tick();
        end
        step(6);
        checks++;
        if ({game_over, busy} !== 2'b10) begin
            failures++;
            $display("FAIL over_hold go=%0b busy=%0b exp 1 0", game_over, busy);
        end
        check_drained("over_drain");
    endtask

    task automatic test_reset_mid_drop();
        push(6, 20, 0, 1'b1);
        pulse_key(3'd1);
        step(2);
        push(6, 19, 0, 1'b1);
        push(6, 18, 0, 1'b1);
        pulse_key(3'd2);
        step(3);
        checks++;
        if ({busy, pos_y} !== {1'b1, 5'd19}) begin
            failures++;
            $display("FAIL mid_drop busy=%0b pos_y=%0d exp 1 19", busy, pos_y);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({game_over, busy, pos_x, pos_y} !== {1'b1, 1'b0, 4'd6, 5'd20}) begin
            failures++;
            $display("FAIL async_reset go=%0b busy=%0b pos=(%0d,%0d) exp 1 0 (6,20)",
                     game_over, busy, pos_x, pos_y);
        end
        check_drained("reset_drain");
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_start();
        test_moves();
        test_key_and_tick();
        test_back_to_back();
        test_hard_drop();
        test_drop_max();
        test_game_over();
        test_reset_mid_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piece_move_sequencer.md
Name: piece_move_sequencer

Overview:
- Control FSM for the falling-piece datapath: converts decoded key events and gravity ticks into moves.
- Validates each candidate move through one shared, time-multiplexed collision checker instead of a combinational checker chain.
- Sequences lock → row-eliminate handshake → spawn → game-over detection.
- Sits between keyboard/gravity pulse sources and the board storage/combine/eliminate logic.

Parameters:
- X_ORI, 6, spawn column of piece origin (4-bit)
- Y_ORI, 20, spawn row of piece origin (5-bit)
- DROP_MAX, 24, max down-steps per hard drop

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle pulse, decoded key event
- key_code  in  3  1=start, 2=hard drop, 3=rotate cw, 4=rotate ccw, 5=left, 6=right; 0/7 ignored
- tick  in  1  one-cycle gravity pulse
- chk_req  out  1  collision-check request, one cycle wide
- chk_x  out  4  candidate column, valid with chk_req
- chk_y  out  5  candidate row, valid with chk_req
- chk_shape  out  2  0=current shape, 1=cw-rotated, 2=ccw-rotated
- chk_ok  in  1  checker result, valid exactly 1 cycle after chk_req
- pos_x  out  4  committed column
- pos_y  out  5  committed row
- rot_cw  out  1  pulse: commit cw rotation into shape register
- rot_ccw  out  1  pulse: commit ccw rotation
- lock_req  out  1  pulse: merge piece at pos into board and start elimination
- lock_done  in  1  pulse: merge + elimination finished
- spawn  out  1  pulse: load new random shape
- clear_req  out  1  pulse: clear board (new game)
- game_over  out  1  level, 1 while no game is running
- busy  out  1  1 in any state except READY and OVER

Behaviour:
- Reset (async, rst_n=0):
  - state=OVER, game_over=1, pos_x=X_ORI, pos_y=Y_ORI
  - all pulse outputs 0, key buffer empty, tick_pend=0
- States: OVER, READY, ISSUE, EVAL, LOCK, LOCK_WAIT, SPAWN, SPAWN_EVAL.
- Event capture (every state):
  - tick sets sticky tick_pend; multiple ticks while pending collapse to one.
  - key_valid with code 2-6 loads a 1-entry key buffer only if empty; otherwise the event is dropped.
- Start key (code 1), accepted in any state (aborts current operation):
  - next cycle: clear_req=1, spawn=1, pos=(X_ORI,Y_ORI), key buffer and tick_pend cleared, game_over=0 → SPAWN.
- OVER: all events other than start are discarded.
- READY arbitration, one per cycle, priority buffered key > tick_pend; the selected source is consumed on entering ISSUE.
- Candidates:
  - cw: (pos, shape 1); ccw: (pos, shape 2)
  - left: (pos_x-1, pos_y, 0); right: (pos_x+1, pos_y, 0)
  - tick/hard-drop step: (pos_x, pos_y-1, 0)
  - 4/5-bit wrap is intentional; the checker rejects out-of-board positions.
- ISSUE: chk_req=1 with candidate → EVAL.
- EVAL: sample chk_ok.
  - ok: commit (pos update or rot pulse) → READY. Hard drop: commit the step; if steps < DROP_MAX → ISSUE with next step, else → LOCK.
  - not ok, rotate/left/right: no change → READY.
  - not ok, tick or hard drop: → LOCK.
- LOCK: lock_req=1 → LOCK_WAIT. Hold until lock_done; lock_done outside LOCK_WAIT is ignored.
- SPAWN (entered from LOCK_WAIT on lock_done, or from start): spawn=1, pos=(X_ORI,Y_ORI), chk_req=1 with shape 0 → SPAWN_EVAL.
- SPAWN_EVAL: chk_ok=1 → READY; chk_ok=0 → OVER, game_over=1.
- Latency:
  - key_valid in READY at cycle t → chk_req at t+1 → pos/rot update visible t+3.
  - Hard drop of n steps: 2n cycles plus a 2-cycle lock entry.
- Simultaneous key_valid and tick in READY: key is served first; the tick stays pending.

Test Plan:
- Reset, then start key → clear_req and spawn pulse together, pos=(6,20); chk_ok=1 in SPAWN_EVAL → READY, game_over=0.
- READY, key 5 with chk_ok=1 → chk_x=5, chk_y=20, chk_shape=0; pos_x=5 at t+3. Repeat with chk_ok=0 → pos_x stays 5, no pulses.
- Key 3 and tick in the same cycle, chk_ok=1 both → rot_cw pulse first, then chk_y=19, then pos_y=19; tick not lost.
- Hard drop from y=20, checker returns ok for y=19..15 and fails at y=14 → pos_y=15, lock_req one cycle after the failing EVAL; lock_done → spawn, pos=(6,20).
- Three ticks while in LOCK_WAIT → exactly one down check after the return to READY.
- Spawn check chk_ok=0 → game_over=1, state OVER; subsequent keys 2-6 and ticks → no chk_req. Assert rst_n mid-hard-drop → immediate OVER, pos=(6,20).
